// File: rtl/led_indicator_driver_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg : shared definitions for the RefLock II LED indicator driver.
//
// Contents
//   led_mode_e   per-channel display mode encoding
//   LED_PWM_W    width of the optional dimming PWM counter and `dim` input
//   mode_lit()   maps a channel mode plus the live blink/stretch state to
//                the logical "lit" value (before polarity and dimming)
//
// Optional feature macro used elsewhere in this slice: LED_DIMMING_EN
// ---------------------------------------------------------------------------
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'b00,
      LED_ON      = 2'b01,
      LED_BLINK   = 2'b10,
      LED_STRETCH = 2'b11
   } led_mode_e;

   localparam int LED_PWM_W = 4;

   // Logical lit value of one channel for its selected mode.
   function automatic logic mode_lit(input led_mode_e mode_s,
                                     input logic      blink_phase_s,
                                     input logic      stretch_on_s);
      logic lit_s;
      case (mode_s)
         LED_OFF:     lit_s = 1'b0;
         LED_ON:      lit_s = 1'b1;
         LED_BLINK:   lit_s = blink_phase_s;
         LED_STRETCH: lit_s = stretch_on_s;
         default:     lit_s = 1'b0;
      endcase
      return lit_s;
   endfunction

endpackage

// File: rtl/led_indicator_driver_if.sv
// ---------------------------------------------------------------------------
// led_indicator_driver_if : status-side bundle of the LED indicator driver.
//
// Signals
//   mode  [2*NUM_LEDS]  per-channel mode, channel i in [2i+1:2i] (led_mode_e)
//   evt   [NUM_LEDS]    per-channel event strobe for STRETCH mode (named evt
//                       because `event` is a reserved word)
//   led   [NUM_LEDS]    registered LED pins, polarity set by the driver
//   tick  [1]           one-cycle timebase strobe
//   dim   [LED_PWM_W]   brightness, present only with LED_DIMMING_EN
//
// Modports
//   master : the status logic / board side driving mode, evt (and dim)
//   slave  : the LED driver itself
//
// Optional feature macro: LED_DIMMING_EN (adds dim)
// ---------------------------------------------------------------------------
interface led_indicator_driver_if #(
   parameter int NUM_LEDS = 2
) ();

   logic [2*NUM_LEDS-1:0] mode;
   logic [NUM_LEDS-1:0]   evt;
   logic [NUM_LEDS-1:0]   led;
   logic                  tick;

`ifdef LED_DIMMING_EN
   logic [led_pkg::LED_PWM_W-1:0] dim;

   modport master (output mode, output evt, output dim, input led, input tick);
   modport slave  (input mode, input evt, input dim, output led, output tick);
`else
   modport master (output mode, output evt, input led, input tick);
   modport slave  (input mode, input evt, output led, output tick);
`endif

endinterface

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen : prescaler producing a shared one-cycle timebase strobe.
//
// Parameters
//   PRESCALE  clk cycles per tick (>= 2)
//
// Ports
//   clk   in   reference clock, rising edge
//   rst   in   asynchronous active-high reset
//   tick  out  registered strobe, high for one cycle every PRESCALE clks;
//              first high PRESCALE cycles after reset release
//
// The prescale counter runs 0..PRESCALE-1 and wraps. The strobe is
// registered from the terminal count, so it is high in the cycle after the
// counter sat at PRESCALE-1. rst is expected to be released synchronously
// to clk by the upstream reset logic.
// ---------------------------------------------------------------------------
module led_tick_gen #(
   parameter int PRESCALE = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            PW        = $clog2(PRESCALE + 1);
   localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PCNT_ONE  = PW'(1'b1);

   logic [PW-1:0] pcnt_r;
   logic          tick_r;
   logic          pcnt_last_s;

   // Terminal-count detect for the prescale counter.
   always_comb begin
      pcnt_last_s = (pcnt_r == PCNT_LAST);
   end

   // Prescale counter with wrap and registered tick strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt_r <= '0;
         tick_r <= 1'b0;
      end else begin
         tick_r <= pcnt_last_s;
         if (pcnt_last_s) begin
            pcnt_r <= '0;
         end else begin
            pcnt_r <= pcnt_r + PCNT_ONE;
         end
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/led_indicator_driver.sv
// ---------------------------------------------------------------------------
// led_indicator_driver : multi-channel LED driver for the RefLock II CPLD.
//
// Each channel selects OFF, ON, BLINK or STRETCH at runtime. BLINK channels
// share one blink counter so they all flash in phase. STRETCH is a
// retriggerable pulse stretcher that keeps a LED lit for STRETCH_TICKS
// ticks after the last event strobe, so single-cycle strobes are visible.
//
// Parameters
//   NUM_LEDS       number of channels (1..8)
//   PRESCALE       clk cycles per tick (>= 2)
//   BLINK_TICKS    ticks per blink half-period (>= 1)
//   STRETCH_TICKS  ticks a LED stays lit after the last event (>= 1)
//   ACTIVE_LOW     1 = pins are lit when low
//
// Ports
//   clk   in     reference clock, rising edge
//   rst   in     asynchronous active-high reset (released synchronously)
//   bus   slave  led_indicator_driver_if: mode, evt, led, tick (+ dim)
//
// Optional feature macro: LED_DIMMING_EN
//   Adds bus.dim and a free-running PWM counter; lit channels are driven
//   only while pwm_cnt < dim, dim == all-ones means fully on, dim == 0
//   means dark. Without the macro lit channels are driven fully.
// ---------------------------------------------------------------------------
module led_indicator_driver
   import led_pkg::*;
#(
   parameter int NUM_LEDS      = 2,
   parameter int PRESCALE      = 100000,
   parameter int BLINK_TICKS   = 25,
   parameter int STRETCH_TICKS = 10,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   led_indicator_driver_if.slave  bus
);

   localparam int            BW         = $clog2(BLINK_TICKS + 1);
   localparam logic [BW-1:0] BCNT_LAST  = BW'(BLINK_TICKS - 1);
   localparam logic [BW-1:0] BCNT_ONE   = BW'(1'b1);

   localparam int            SW         = $clog2(STRETCH_TICKS + 1);
   localparam logic [SW-1:0] SCNT_LOAD  = SW'(STRETCH_TICKS);
   localparam logic [SW-1:0] SCNT_ONE   = SW'(1'b1);

   localparam logic                al_bit_c   = (ACTIVE_LOW != 0);
   localparam logic [NUM_LEDS-1:0] UNLIT_PINS = {NUM_LEDS{al_bit_c}};

   logic                tick_s;
   logic [BW-1:0]       bcnt_r;
   logic                blink_phase_r;
   logic [SW-1:0]       scnt_r [NUM_LEDS];
   logic [NUM_LEDS-1:0] stretch_on_s;
   logic                drive_gate_s;
   logic [NUM_LEDS-1:0] lit_s;
   logic [NUM_LEDS-1:0] led_r;

   // Shared timebase; also exported on bus.tick for other timers.
   led_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Shared blink counter; the phase flips at the end of every half-period,
   // so the first lit half starts after BLINK_TICKS ticks from reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_r        <= '0;
         blink_phase_r <= 1'b0;
      end else if (tick_s) begin
         if (bcnt_r == BCNT_LAST) begin
            bcnt_r        <= '0;
            blink_phase_r <= ~blink_phase_r;
         end else begin
            bcnt_r <= bcnt_r + BCNT_ONE;
         end
      end
   end

   // Per-channel stretch counters. They run in every mode so that switching
   // into STRETCH shows the current state. An event reloads the full count
   // and wins over a same-cycle tick decrement.
   for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_stretch
      // Stretch counter for channel gi.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            scnt_r[gi] <= '0;
         end else if (bus.evt[gi]) begin
            scnt_r[gi] <= SCNT_LOAD;
         end else if (tick_s && (scnt_r[gi] != '0)) begin
            scnt_r[gi] <= scnt_r[gi] - SCNT_ONE;
         end
      end

      // The live event also lights the LED so the pin follows the strobe
      // with a single clk of latency.
      assign stretch_on_s[gi] = (scnt_r[gi] != '0) || bus.evt[gi];
   end

`ifdef LED_DIMMING_EN
   logic [LED_PWM_W-1:0] pwm_cnt_r;

   // Free-running PWM counter for brightness control.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_r <= '0;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + LED_PWM_W'(1'b1);
      end
   end

   // All-ones dim keeps lit channels on; otherwise compare against PWM.
   always_comb begin
      if (bus.dim == {LED_PWM_W{1'b1}}) begin
         drive_gate_s = 1'b1;
      end else begin
         drive_gate_s = (pwm_cnt_r < bus.dim);
      end
   end
`else
   // No dimming: lit channels are always driven.
   always_comb begin
      drive_gate_s = 1'b1;
   end
`endif

   // Logical lit value per channel, gated by brightness.
   always_comb begin
      lit_s = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         lit_s[i] = mode_lit(led_mode_e'(bus.mode[2*i +: 2]),
                             blink_phase_r, stretch_on_s[i]) & drive_gate_s;
      end
   end

   // Output register with pin polarity applied; unlit during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_r <= UNLIT_PINS;
      end else begin
         led_r <= lit_s ^ UNLIT_PINS;
      end
   end

   assign bus.led  = led_r;
   assign bus.tick = tick_s;

endmodule

// File: tb/tb_led_indicator_driver.sv
// ---------------------------------------------------------------------------
// tb_led_indicator_driver : directed bench for led_indicator_driver.
// Two instances share clk/rst: dut_h (ACTIVE_LOW=0) and dut_l (ACTIVE_LOW=1),
// both with PRESCALE=4, BLINK_TICKS=2, STRETCH_TICKS=3, NUM_LEDS=2.
// Step comments give e = number of rising edges since the last reset release.
// Ticks are visible after e = 4, 8, 12, ...; blink phase toggles at
// e = 9, 17, 25, ... (lit from e = 9 to 16, 25 to 32, ...).
// ---------------------------------------------------------------------------
module tb_led_indicator_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   led_indicator_driver_if #(.NUM_LEDS(2)) bus_h ();
   led_indicator_driver_if #(.NUM_LEDS(2)) bus_l ();

   led_indicator_driver #(
      .NUM_LEDS(2), .PRESCALE(4), .BLINK_TICKS(2), .STRETCH_TICKS(3), .ACTIVE_LOW(0)
   ) dut_h (
      .clk (clk),
      .rst (rst),
      .bus (bus_h)
   );

   led_indicator_driver #(
      .NUM_LEDS(2), .PRESCALE(4), .BLINK_TICKS(2), .STRETCH_TICKS(3), .ACTIVE_LOW(1)
   ) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bus_l)
   );

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input logic [3:0] m, input logic [1:0] ev);
      bus_h.mode = m;
      bus_l.mode = m;
      bus_h.evt  = ev;
      bus_l.evt  = ev;
   endtask

   initial begin
`ifdef LED_DIMMING_EN
      bus_h.dim = 4'hF;
      bus_l.dim = 4'hF;
`endif
      set_in(4'b0000, 2'b00);
      rst = 1'b1;
      adv(3);
      chk("rst_led_h", bus_h.led, 2'b00);
      chk("rst_led_l", bus_l.led, 2'b11);
      chk("rst_tick", {1'b0, bus_h.tick}, 2'b00);

      // e=0: release, ch1 ON, ch0 OFF
      rst = 1'b0;
      set_in(4'b0100, 2'b00);
      adv(1);  // e=1
      chk("on_led_h", bus_h.led, 2'b10);
      chk("on_led_l", bus_l.led, 2'b01);
      chk("tick_e1", {1'b0, bus_h.tick}, 2'b00);
      adv(2);  // e=3
      chk("tick_e3", {1'b0, bus_h.tick}, 2'b00);
      adv(1);  // e=4
      chk("tick_e4", {1'b0, bus_h.tick}, 2'b01);
      chk("on_hold_e4", bus_h.led, 2'b10);
      adv(1);  // e=5
      chk("tick_e5", {1'b0, bus_h.tick}, 2'b00);
      adv(3);  // e=8
      chk("tick_e8", {1'b0, bus_h.tick}, 2'b01);
      chk("on_hold_e8", bus_h.led, 2'b10);

      // both BLINK; shared timebase keeps running
      set_in(4'b1010, 2'b00);
      adv(1);  // e=9
      chk("blink_e9", bus_h.led, 2'b00);
      adv(1);  // e=10
      chk("blink_e10", bus_h.led, 2'b11);
      chk("blink_l_e10", bus_l.led, 2'b00);
      adv(7);  // e=17
      chk("blink_e17", bus_h.led, 2'b11);
      adv(1);  // e=18
      chk("blink_e18", bus_h.led, 2'b00);
      adv(7);  // e=25
      chk("blink_e25", bus_h.led, 2'b00);
      adv(1);  // e=26
      chk("blink_e26", bus_h.led, 2'b11);

      // ch0 STRETCH, ch1 OFF
      set_in(4'b0011, 2'b00);
      adv(1);  // e=27
      chk("str_idle", bus_h.led, 2'b00);
      set_in(4'b0011, 2'b01);
      adv(1);  // e=28: scnt0=3
      chk("str_evt", bus_h.led, 2'b01);
      set_in(4'b0011, 2'b00);
      adv(5);  // e=33: scnt0=1
      chk("str_e33", bus_h.led, 2'b01);
      adv(4);  // e=37: scnt0 reaches 0
      chk("str_e37", bus_h.led, 2'b01);
      adv(1);  // e=38
      chk("str_off", bus_h.led, 2'b00);

      // retrigger at scnt==1 coinciding with a tick: reload wins
      set_in(4'b0011, 2'b01);
      adv(1);  // e=39: scnt0=3
      chk("str2_evt", bus_h.led, 2'b01);
      set_in(4'b0011, 2'b00);
      adv(9);  // e=48: scnt0=1, tick pending
      chk("str2_e48", bus_h.led, 2'b01);
      set_in(4'b0011, 2'b01);
      adv(1);  // e=49: reload to 3
      chk("retrig_e49", bus_h.led, 2'b01);
      set_in(4'b0011, 2'b00);
      adv(12); // e=61: scnt0 reaches 0
      chk("retrig_e61", bus_h.led, 2'b01);
      adv(1);  // e=62
      chk("retrig_off", bus_h.led, 2'b00);

      // event held high keeps the LED lit
      set_in(4'b0011, 2'b01);
      adv(1);  // e=63
      chk("held_e63", bus_h.led, 2'b01);
      adv(12); // e=75
      chk("held_e75", bus_h.led, 2'b01);

      // ch1 STRETCH, ch0 BLINK (phase 1 from e=73)
      set_in(4'b1110, 2'b10);
      adv(1);  // e=76
      chk("pre_rst_h", bus_h.led, 2'b11);
      chk("pre_rst_l", bus_l.led, 2'b00);
      set_in(4'b1110, 2'b00);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_h", bus_h.led, 2'b00);
      chk("async_rst_l", bus_l.led, 2'b11);
      chk("async_rst_tick", {1'b0, bus_h.tick}, 2'b00);
      adv(2);
      rst = 1'b0;  // e=0
      adv(1);  // e=1
      chk("post_rst_e1", bus_h.led, 2'b00);
      adv(3);  // e=4
      chk("post_rst_e4", bus_h.led, 2'b00);
      chk("post_rst_tick", {1'b0, bus_h.tick}, 2'b01);
      adv(5);  // e=9
      chk("post_rst_e9", bus_h.led, 2'b00);
      adv(1);  // e=10
      chk("post_rst_e10", bus_h.led, 2'b01);
      chk("post_rst_l_e10", bus_l.led, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
